// File: rtl/chip_7458_pkg.sv
// Shared types and constants for the 7458 pin-level exerciser.
// Vector layout: p1 pins occupy the low field, p2 pins the high field.
package chip_7458_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int NUM_VECTORS = 1024;
  localparam int VEC_W       = 10;
  localparam int P1_LSB      = 0;
  localparam int P1_W        = 6;
  localparam int P2_LSB      = 6;
  localparam int P2_W        = 4;
  localparam int ERR_W       = 11;

endpackage

// File: rtl/chip_7458_if.sv
// Pin bundle between the exerciser (master) and the 7458 model (slave).
interface chip_7458_if;
  import chip_7458_pkg::*;

  logic [P1_W-1:0] p1_drv;
  logic [P2_W-1:0] p2_drv;
  logic            p1y_in;
  logic            p2y_in;

  modport master (output p1_drv, output p2_drv, input p1y_in, input p2y_in);
  modport slave  (input p1_drv, input p2_drv, output p1y_in, output p2y_in);

endinterface

// File: rtl/chip_7458_golden.sv
// Combinational expected outputs of a fault-free 7458 for the given pin values.
module chip_7458_golden
  import chip_7458_pkg::*;
(
  input  logic [P1_W-1:0] p1_drv,
  input  logic [P2_W-1:0] p2_drv,
  output logic            exp1,
  output logic            exp2
);

  // p1: {f,e,d,c,b,a}, p2: {d,c,b,a}
  assign exp1 = (&p1_drv[2:0]) | (&p1_drv[5:3]);
  assign exp2 = (&p2_drv[1:0]) | (&p2_drv[3:2]);

endmodule

// File: rtl/chip_7458_tester.sv
// Walks all 1024 input combinations into a 7458, waits SETTLE_CYCLES, samples
// both outputs against the golden model and accumulates error statistics.
module chip_7458_tester
  import chip_7458_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  chip_7458_if.master       pins,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [VEC_W-1:0]  first_fail_vec,
  output logic              first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q;
  logic [3:0]       settle_q;
  logic [ERR_W-1:0] err_q;
  logic [VEC_W-1:0] ffv_q;
  logic             ffvalid_q;

  logic             active;
  logic             last_vec;
  logic             exp1, exp2;
  logic             mismatch;
  logic [P1_W-1:0]  p1_w;
  logic [P2_W-1:0]  p2_w;

  assign active   = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                    (state_q == ST_SAMPLE);
  assign last_vec = (vec_q == VEC_W'(NUM_VECTORS - 1));

  // Pins are parked low whenever no run is in progress.
  assign p1_w        = active ? vec_q[P1_LSB +: P1_W] : '0;
  assign p2_w        = active ? vec_q[P2_LSB +: P2_W] : '0;
  assign pins.p1_drv = p1_w;
  assign pins.p2_drv = p2_w;

  chip_7458_golden u_golden (
    .p1_drv (p1_w),
    .p2_drv (p2_w),
    .exp1   (exp1),
    .exp2   (exp2)
  );

  assign mismatch = (pins.p1y_in != exp1) || (pins.p2y_in != exp2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
      ST_DRIVE:         state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE:        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE:        state_d = last_vec ? ST_DONE : ST_DRIVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q     <= '0;
      settle_q  <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
          end
        end
        ST_DRIVE:  settle_q <= '0;
        ST_SETTLE: settle_q <= settle_q + 4'd1;
        ST_SAMPLE: begin
          // Only the earliest failure is kept; later ones just count.
          if (mismatch) begin
            err_q <= err_q + ERR_W'(1);
            if (!ffvalid_q) begin
              ffv_q     <= vec_q;
              ffvalid_q <= 1'b1;
            end
          end
          if (!last_vec) vec_q <= vec_q + VEC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy             = active;
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_chip_7458_tester.sv
// Directed bench: good and faulty 7458 models, reset abort, restart and
// start-while-busy behaviour, plus a zero-settle instance.
module tb_chip_7458_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   fault = 0;   // 0 good, 1 p1y stuck-at-0, 2 p2y stuck-at-1

  int total = 0;
  int bad   = 0;

  logic        busy0, done0, pass0, ffvalid0;
  logic [10:0] err0;
  logic [9:0]  ffv0;
  logic        busy1, done1, pass1, ffvalid1;
  logic [10:0] err1;
  logic [9:0]  ffv1;

  chip_7458_if pins0 ();
  chip_7458_if pins1 ();

  always #5 clk = ~clk;

  function automatic logic m_y1(input logic [5:0] p);
    return (p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]);
  endfunction

  function automatic logic m_y2(input logic [3:0] p);
    return (p[0] & p[1]) | (p[2] & p[3]);
  endfunction

  assign pins0.p1y_in = (fault == 1) ? 1'b0 : m_y1(pins0.p1_drv);
  assign pins0.p2y_in = (fault == 2) ? 1'b1 : m_y2(pins0.p2_drv);
  assign pins1.p1y_in = m_y1(pins1.p1_drv);
  assign pins1.p2y_in = m_y2(pins1.p2_drv);

  chip_7458_tester #(.SETTLE_CYCLES(2)) dut0 (
    .clk (clk), .rst (rst), .start (start0), .pins (pins0),
    .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
    .first_fail_vec (ffv0), .first_fail_valid (ffvalid0)
  );

  chip_7458_tester #(.SETTLE_CYCLES(0)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .pins (pins1),
    .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
    .first_fail_vec (ffv1), .first_fail_valid (ffvalid1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulses start on the selected instance and counts edges until done.
  task automatic run(input bit sel, input int mid, input int exp_edges, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    chk({tag, "_busy_hi"}, sel ? busy1 : busy0, 1);
    chk({tag, "_done_lo"}, sel ? done1 : done0, 0);
    chk({tag, "_err_clr"}, sel ? err1 : err0, 0);
    chk({tag, "_ffvalid_clr"}, sel ? ffvalid1 : ffvalid0, 0);
    while (!(sel ? done1 : done0) && n < 20000) begin
      if (n == mid) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      n++;
    end
    chk({tag, "_edges"}, n, exp_edges);
    chk({tag, "_busy_lo"}, sel ? busy1 : busy0, 0);
  endtask

  initial begin
    int n;
    logic [9:0] v;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_p1", pins0.p1_drv, 0);
    chk("rst_p2", pins0.p2_drv, 0);
    @(negedge clk);
    rst = 1'b0;

    fault = 0;
    run(1'b0, -1, 4096, "good");
    chk("good_err", err0, 0);
    chk("good_pass", pass0, 1);
    chk("good_ffvalid", ffvalid0, 0);
    chk("good_done_pins", pins0.p1_drv, 0);

    fault = 1;
    run(1'b0, -1, 4096, "p1s0");
    chk("p1s0_err", err0, 240);
    chk("p1s0_ffv", ffv0, 10'h007);
    chk("p1s0_ffvalid", ffvalid0, 1);
    chk("p1s0_pass", pass0, 0);

    // Restart from DONE after a failing run, with a stray start mid-run.
    fault = 0;
    run(1'b0, 1000, 4096, "rerun");
    chk("rerun_pass", pass0, 1);
    chk("rerun_err", err0, 0);

    fault = 2;
    run(1'b0, -1, 4096, "p2s1");
    chk("p2s1_err", err0, 576);
    chk("p2s1_ffv", ffv0, 10'h000);
    chk("p2s1_ffvalid", ffvalid0, 1);
    chk("p2s1_pass", pass0, 0);

    // Abort at vector 100 with errors already accumulated.
    fault = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    v = {pins0.p2_drv, pins0.p1_drv};
    while (v != 10'd100 && n < 2000) begin
      @(posedge clk); #1;
      v = {pins0.p2_drv, pins0.p1_drv};
      n++;
    end
    chk("abort_reached", (v == 10'd100), 1);
    chk("abort_err_pre", (err0 != 0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_err", err0, 0);
    chk("abort_ffvalid", ffvalid0, 0);
    chk("abort_ffv", ffv0, 0);
    chk("abort_p1", pins0.p1_drv, 0);
    chk("abort_p2", pins0.p2_drv, 0);
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    run(1'b0, -1, 4096, "post_abort");
    chk("post_abort_pass", pass0, 1);

    run(1'b1, -1, 2048, "zs");
    chk("zs_pass", pass1, 1);
    chk("zs_err", err1, 0);
    chk("zs_ffvalid", ffvalid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_7458_tester.md
Name: chip_7458_tester

Overview:
- Sequential pin-level exerciser for a 7458 dual AND-OR gate model.
- Drives the chip's 10 input pins through all 1024 combinations, waits a programmable settle time, samples p1y/p2y and compares them against golden AND-OR values.
- Reports an error count, the first failing vector and pass/done status.
- Sits on the bench or board side, opposite the chip: it drives what the chip reads and reads what the chip drives.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling outputs; range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request.
- p1_drv  output  6  to chip {p1f,p1e,p1d,p1c,p1b,p1a}.
- p2_drv  output  4  to chip {p2d,p2c,p2b,p2a}.
- p1y_in  input  1  from chip p1y.
- p2y_in  input  1  from chip p2y.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  11  number of failing vectors, 0..1024.
- first_fail_vec  output  10  first failing vector index.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async, rst=1): state=IDLE; vec=0; all outputs 0; p1_drv=p2_drv=0.
- Vector mapping: vec[5:0]→p1_drv, vec[9:6]→p2_drv.
- In DRIVE/SETTLE/SAMPLE the pins are driven from registered vec. In IDLE and DONE the pins are 0.
- Golden values:
  - exp1 = (a&b&c)|(d&e&f), using the p1 pins.
  - exp2 = (a&b)|(c&d), using the p2 pins.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: on start, clear vec, err_count and first_fail_*; go to DRIVE.
- DRIVE: 1 cycle; go to SETTLE, or to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: settle counter runs SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: 1 cycle; compare on the exiting edge.
  - Mismatch (p1y_in!=exp1 OR p2y_in!=exp2) increments err_count by exactly 1 per vector.
  - On the first mismatch, capture first_fail_vec=vec and set first_fail_valid.
  - If vec==1023, go to DONE; otherwise vec+1 and go to DRIVE.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - busy rises on the edge that samples start.
  - done rises exactly 1024*(SETTLE_CYCLES+2) edges later; busy falls on the same edge.
- DONE: done=1, busy=0, results stable. start restarts the run as from IDLE (clear, go to DRIVE).
- start while busy is ignored.
- err_count is 11 bits, so 1024 failures does not wrap. vec wrap is never reached, because the run terminates at 1023.
- rst mid-run aborts immediately to reset values; no partial results are retained.
- pass is combinational from done and err_count==0.

Decomposition:
- Package chip_7458_pkg holds:
  - state enum;
  - NUM_VECTORS=1024;
  - P1 and P2 field positions/widths within vec;
  - ERR_W=11.
- Sub-module chip_7458_golden is a pure combinational expected-value generator (p1_drv, p2_drv → exp1, exp2). It is instantiated once inside the tester and is reusable by the verification bench.

Test Plan:
- Good 7458 model, SETTLE_CYCLES=2, start pulse:
  - busy=1 next cycle; done rises 4096 edges after start;
  - err_count=0, pass=1, first_fail_valid=0.
- p1y stuck-at-0:
  - err_count=240 (15 true p1 combos ×16);
  - first_fail_vec=10'h007, pass=0.
- p2y stuck-at-1:
  - err_count=576 (9 false p2 combos ×64);
  - first_fail_vec=10'h000.
- Reset mid-run (rst at vector 100):
  - all outputs 0 and pins 0 immediately;
  - a subsequent start completes the full run with pass=1.
- Protocol checks:
  - start pulsed mid-run is ignored; done timing is unchanged.
  - start in DONE after a failing run clears err_count to 0 on the next edge and reruns.
- SETTLE_CYCLES=0, good model: done 2048 edges after start, pass=1.
